// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive framer.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;
  localparam int   OVERSAMPLE_DEF = 16;
  localparam int   MID_TICK       = OVERSAMPLE_DEF/2 - 1;
  localparam logic IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Mid-bit tick index for a non-default oversample ratio.
  function automatic int mid_tick_of(input int os);
    return os/2 - 1;
  endfunction
endpackage

// File: rtl/uart_rx_tick_gen.sv
// Divides clk by BAUD_DIV into single-cycle oversample ticks while enabled.
module uart_rx_tick_gen #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(BAUD_DIV-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + CW'(1);
  end
endmodule

// File: rtl/uart_rx_framer.sv
// Oversampling UART receiver with a one-deep output holding register.
// Define UART_RX_PARITY_EN to receive and check an even-parity bit.
module uart_rx_framer
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  framing_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  output logic                  busy
);
  localparam int MID = mid_tick_of(OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_WIDTH + 1);

  state_t                state, state_next;
  logic                  rx_meta, rx_s, rx_prev, armed;
  logic [OSW-1:0]        os_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  tick, start_clr, bit_done, mid_start, commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= IDLE_LEVEL;
      rx_s    <= IDLE_LEVEL;
      rx_prev <= IDLE_LEVEL;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign busy      = (state != IDLE);
  assign start_clr = (state == IDLE) && (state_next == START);
  assign bit_done  = tick && (os_cnt == OSW'(OVERSAMPLE-1));
  assign mid_start = tick && (os_cnt == OSW'(MID));

  uart_rx_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (start_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE:  if (armed && rx_prev && !rx_s) state_next = START;
      START: if (mid_start) state_next = (rx_s == IDLE_LEVEL) ? IDLE : DATA;
      DATA:  if (bit_done && bit_cnt == BCW'(DATA_WIDTH-1))
`ifdef UART_RX_PARITY_EN
               state_next = PARITY;
      PARITY: if (bit_done) state_next = STOP;
`else
               state_next = STOP;
`endif
      STOP: if (bit_done) begin
        state_next = IDLE;
        commit     = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // os_cnt restarts at the start-bit midpoint so later wraps land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      armed   <= 1'b1;
    end else begin
      if (state == IDLE) begin
        os_cnt  <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        if ((state == START && os_cnt == OSW'(MID)) || os_cnt == OSW'(OVERSAMPLE-1))
          os_cnt <= '0;
        else
          os_cnt <= os_cnt + OSW'(1);
      end
      if (state == DATA && bit_done) begin
        shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + BCW'(1);
      end
      // A break keeps the line low; wait for it to go high before re-arming.
      if (commit && !rx_s && shreg == '0) armed <= 1'b0;
      else if (state == IDLE && rx_s)     armed <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            par_bit <= 1'b0;
    else if (state == PARITY && bit_done) par_bit <= rx_s;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (commit) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= shreg;
          framing_err <= !rx_s;
          frame_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else if (commit && (!frame_valid || frame_ready)) parity_err <= ^shreg ^ par_bit;
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule
